// File: rtl/arith_bist_ctrl.sv
// -----------------------------------------------------------------------------
// arith_bist_ctrl
//   Sequential built-in self-test controller for the arithmetic datapath
//   (A = x1*K1 + x2*K2, B = v*t + c). On start it generates NUM_VECTORS operand
//   sets from a 32-bit Galois LFSR and presents each one with op_valid. It then
//   waits up to TIMEOUT cycles for res_valid and compares the returned results
//   against an internal golden model. It reports pass, fail_count and
//   first_fail_idx.
//
// Optional feature (macro ARITH_BIST_SIGNATURE_EN):
//   Adds a 32-bit MISR output 'signature' that compacts every returned result.
//   A timed-out vector contributes 32'hDEADBEEF to the signature.
//
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   start              single-cycle pulse, accepted only when idle
//   x1,x2,v,t,c        operands to the datapath (W bits each)
//   op_valid           operands stable and valid (DRIVE through WAIT)
//   dut_a, dut_b       datapath results (2W bits each)
//   res_valid          results valid, sampled only while waiting
//   busy               run in progress (GEN through FINISH)
//   done               one-cycle pulse at the end of a run
//   pass               last run had zero failures
//   fail_count         failing vectors in the last run (saturating)
//   first_fail_idx     index of the first failing vector, 16'hFFFF if none
//   signature          MISR result (only with ARITH_BIST_SIGNATURE_EN)
// -----------------------------------------------------------------------------
module arith_bist_ctrl #(
    parameter int          W           = 8,
    parameter int          K1          = 3,
    parameter int          K2          = 5,
    parameter int          NUM_VECTORS = 16,
    parameter int          TIMEOUT     = 15,
    parameter logic [31:0] SEED        = 32'h00000001
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic [W-1:0]     x1,
    output logic [W-1:0]     x2,
    output logic [W-1:0]     v,
    output logic [W-1:0]     t,
    output logic [W-1:0]     c,
    output logic             op_valid,
    input  logic [2*W-1:0]   dut_a,
    input  logic [2*W-1:0]   dut_b,
    input  logic             res_valid,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [15:0]      fail_count,
    output logic [15:0]      first_fail_idx
`ifdef ARITH_BIST_SIGNATURE_EN
    ,
    output logic [31:0]      signature
`endif
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_GEN    = 3'd1;
    localparam logic [2:0] S_DRIVE  = 3'd2;
    localparam logic [2:0] S_WAIT   = 3'd3;
    localparam logic [2:0] S_CHECK  = 3'd4;
    localparam logic [2:0] S_FINISH = 3'd5;

    localparam int          W2        = 2 * W;
    localparam logic [31:0] SEED_EFF  = (SEED == 32'd0) ? 32'd1 : SEED;
    localparam logic [W2-1:0] K1_C    = W2'(K1);
    localparam logic [W2-1:0] K2_C    = W2'(K2);
    localparam logic [7:0]  TIMEOUT_C = 8'(TIMEOUT);
    localparam logic [15:0] LAST_IDX  = 16'(NUM_VECTORS - 1);
    localparam logic [15:0] NO_FAIL   = 16'hFFFF;

    // One step of the shared 32-bit Galois register (LFSR and MISR).
    function automatic logic [31:0] galois_step(input logic [31:0] s);
        galois_step = {1'b0, s[31:1]} ^ (s[0] ? 32'h80200003 : 32'h00000000);
    endfunction

    logic [2:0]    state;
    logic [31:0]   lfsr;
    logic [31:0]   lfsr_next;
    logic [2:0]    gen_cnt;
    logic [7:0]    wait_cnt;
    logic [15:0]   idx;
    logic [W2-1:0] exp_a;
    logic [W2-1:0] exp_b;
    logic [W2-1:0] lat_a;
    logic [W2-1:0] lat_b;
    logic          timed_out;
    logic          vec_fail;
    logic [15:0]   fail_count_inc;

`ifdef ARITH_BIST_SIGNATURE_EN
    logic [31:0] res_a_ext;
    logic [31:0] res_b_ext;
    logic [31:0] misr_in;
`endif

    // Next LFSR value, per-vector verdict and saturating fail increment.
    always_comb begin
        lfsr_next = galois_step(lfsr);
        vec_fail  = timed_out | (lat_a != exp_a) | (lat_b != exp_b);
        if (fail_count == 16'hFFFF) begin
            fail_count_inc = fail_count;
        end else begin
            fail_count_inc = fail_count + 16'd1;
        end
    end

`ifdef ARITH_BIST_SIGNATURE_EN
    // MISR input word: low 16 bits of each result, or a marker on timeout.
    always_comb begin
        res_a_ext = 32'(lat_a);
        res_b_ext = 32'(lat_b);
        if (timed_out) begin
            misr_in = 32'hDEADBEEF;
        end else begin
            misr_in = {res_a_ext[15:0], res_b_ext[15:0]};
        end
    end
`endif

    // Controller FSM with all registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= S_IDLE;
            lfsr           <= SEED_EFF;
            gen_cnt        <= 3'd0;
            wait_cnt       <= 8'd0;
            idx            <= 16'd0;
            exp_a          <= '0;
            exp_b          <= '0;
            lat_a          <= '0;
            lat_b          <= '0;
            timed_out      <= 1'b0;
            x1             <= '0;
            x2             <= '0;
            v              <= '0;
            t              <= '0;
            c              <= '0;
            op_valid       <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            fail_count     <= 16'd0;
            first_fail_idx <= NO_FAIL;
`ifdef ARITH_BIST_SIGNATURE_EN
            signature      <= 32'd0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        fail_count     <= 16'd0;
                        first_fail_idx <= NO_FAIL;
                        idx            <= 16'd0;
                        gen_cnt        <= 3'd0;
                        pass           <= 1'b0;
                        busy           <= 1'b1;
`ifdef ARITH_BIST_SIGNATURE_EN
                        signature      <= 32'd0;
`endif
                        state          <= S_GEN;
                    end
                end
                S_GEN: begin
                    // One LFSR step per operand, captured in x1,x2,v,t,c order.
                    lfsr <= lfsr_next;
                    case (gen_cnt)
                        3'd0:    x1 <= lfsr_next[W-1:0];
                        3'd1:    x2 <= lfsr_next[W-1:0];
                        3'd2:    v  <= lfsr_next[W-1:0];
                        3'd3:    t  <= lfsr_next[W-1:0];
                        default: c  <= lfsr_next[W-1:0];
                    endcase
                    if (gen_cnt == 3'd4) begin
                        op_valid <= 1'b1;
                        state    <= S_DRIVE;
                    end else begin
                        gen_cnt  <= gen_cnt + 3'd1;
                    end
                end
                S_DRIVE: begin
                    exp_a     <= ({{W{1'b0}}, x1} * K1_C) + ({{W{1'b0}}, x2} * K2_C);
                    exp_b     <= ({{W{1'b0}}, v} * {{W{1'b0}}, t}) + {{W{1'b0}}, c};
                    wait_cnt  <= 8'd0;
                    timed_out <= 1'b0;
                    state     <= S_WAIT;
                end
                S_WAIT: begin
                    // A response wins over a timeout landing in the same cycle.
                    if (res_valid) begin
                        lat_a    <= dut_a;
                        lat_b    <= dut_b;
                        op_valid <= 1'b0;
                        state    <= S_CHECK;
                    end else if ((wait_cnt + 8'd1) == TIMEOUT_C) begin
                        timed_out <= 1'b1;
                        op_valid  <= 1'b0;
                        state     <= S_CHECK;
                    end else begin
                        wait_cnt  <= wait_cnt + 8'd1;
                    end
                end
                S_CHECK: begin
                    if (vec_fail) begin
                        fail_count <= fail_count_inc;
                        if (first_fail_idx == NO_FAIL) begin
                            first_fail_idx <= idx;
                        end
                    end
`ifdef ARITH_BIST_SIGNATURE_EN
                    signature <= galois_step(signature) ^ misr_in;
`endif
                    if (idx == LAST_IDX) begin
                        state   <= S_FINISH;
                    end else begin
                        idx     <= idx + 16'd1;
                        gen_cnt <= 3'd0;
                        state   <= S_GEN;
                    end
                end
                S_FINISH: begin
                    done  <= 1'b1;
                    pass  <= (fail_count == 16'd0);
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    op_valid <= 1'b0;
                    busy     <= 1'b0;
                    state    <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_arith_bist_ctrl.sv
// -----------------------------------------------------------------------------
// tb_arith_bist_ctrl
//   Scoreboard bench for arith_bist_ctrl (W=8, K1=3, K2=5, 16 vectors,
//   TIMEOUT=4). A behavioural model predicts every operand set and each run's
//   verdict and latency. A monitor compares them whenever op_valid rises or done
//   pulses. A responder emulates the datapath with programmable delay, a single
//   corrupted vector, or no response at all.
// -----------------------------------------------------------------------------
module tb_arith_bist_ctrl;

    localparam int W  = 8;
    localparam int NV = 16;
    localparam int TO = 4;
    localparam int NO_FAULT = -100;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  x1, x2, v, t, c;
    logic        op_valid;
    logic [15:0] dut_a, dut_b;
    logic        res_valid;
    logic        busy, done, pass;
    logic [15:0] fail_count, first_fail_idx;
`ifdef ARITH_BIST_SIGNATURE_EN
    logic [31:0] signature;
`endif

    arith_bist_ctrl #(
        .W(W), .K1(3), .K2(5), .NUM_VECTORS(NV), .TIMEOUT(TO), .SEED(32'h00000001)
    ) dut (
        .clk(clk), .rst(rst), .start(start),
        .x1(x1), .x2(x2), .v(v), .t(t), .c(c),
        .op_valid(op_valid), .dut_a(dut_a), .dut_b(dut_b), .res_valid(res_valid),
        .busy(busy), .done(done), .pass(pass),
        .fail_count(fail_count), .first_fail_idx(first_fail_idx)
`ifdef ARITH_BIST_SIGNATURE_EN
        ,
        .signature(signature)
`endif
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- datapath responder ----------------
    int resp_delay = 0;
    bit resp_never = 1'b0;
    int fault_idx  = NO_FAULT;
    int ov_cnt     = 0;
    int vec_no     = 0;
    int cyc        = 0;
    int start_cyc  = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (rst) begin
            ov_cnt <= 0;
            vec_no <= 0;
        end else begin
            if (start && !busy) vec_no <= 0;
            else if (op_valid && ov_cnt == 0) vec_no <= vec_no + 1;
            ov_cnt <= op_valid ? ov_cnt + 1 : 0;
        end
    end

    always_comb begin
        res_valid = op_valid && !resp_never && (ov_cnt >= resp_delay + 1);
        dut_a     = 16'(x1) * 16'd3 + 16'(x2) * 16'd5;
        dut_b     = (16'(v) * 16'(t) + 16'(c)) ^ ((fault_idx == vec_no - 1) ? 16'd1 : 16'd0);
    end

    // ---------------- reference model ----------------
    typedef struct {
        logic pass;
        int   fc;
        int   ffi;
        int   lat;
    } res_t;

    logic [31:0] m_lfsr = 32'd1;
    logic [39:0] ops_q[$];
    res_t        res_q[$];

    function automatic logic [31:0] prng(input logic [31:0] s);
        logic [31:0] r;
        r = s >> 1;
        if (s[0]) r = r ^ 32'h80200003;
        return r;
    endfunction

    task automatic model_run();
        res_t r;
        int   fails = 0;
        int   first = 16'hFFFF;
        int   lat   = 0;
        for (int i = 0; i < NV; i++) begin
            logic [7:0] o[5];
            bit to;
            for (int k = 0; k < 5; k++) begin
                m_lfsr = prng(m_lfsr);
                o[k] = m_lfsr[7:0];
            end
            ops_q.push_back({o[0], o[1], o[2], o[3], o[4]});
            to = resp_never || (resp_delay + 1 > TO);
            if (to || i == fault_idx) begin
                fails++;
                if (first == 16'hFFFF) first = i;
            end
            lat += 5 + 1 + (to ? TO : resp_delay + 1) + 1;
        end
        r.pass = (fails == 0);
        r.fc   = fails;
        r.ffi  = first;
        r.lat  = lat + 1;
        res_q.push_back(r);
    endtask

    // ---------------- monitor ----------------
    logic        ov_prev = 1'b0;
    logic [39:0] ops_prev = '0;
    logic [39:0] mon_exp;
    res_t        mon_r;

    always @(negedge clk) begin
        if (!rst) begin
            if (op_valid && !ov_prev) begin
                if (ops_q.size() == 0) begin
                    chk("op_valid_unexpected", 64'd1, 64'd0);
                end else begin
                    mon_exp = ops_q.pop_front();
                    chk("operands", {x1, x2, v, t, c}, mon_exp);
                end
            end else if (op_valid && ov_prev) begin
                chk("operands_stable", {x1, x2, v, t, c}, ops_prev);
            end
            if (done) begin
                if (res_q.size() == 0) begin
                    chk("done_unexpected", 64'd1, 64'd0);
                end else begin
                    mon_r = res_q.pop_front();
                    chk("pass", pass, mon_r.pass);
                    chk("fail_count", fail_count, mon_r.fc);
                    chk("first_fail_idx", first_fail_idx, mon_r.ffi);
                    chk("done_latency", cyc - start_cyc, mon_r.lat);
                    chk("busy_at_done", busy, 0);
                end
            end
        end
        ov_prev  <= op_valid;
        ops_prev <= {x1, x2, v, t, c};
    end

    // ---------------- stimulus ----------------
    task automatic check_reset(input string tag);
        chk({tag, "_operands"}, {x1, x2, v, t, c}, 40'd0);
        chk({tag, "_op_valid"}, op_valid, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_pass"}, pass, 0);
        chk({tag, "_fail_count"}, fail_count, 0);
        chk({tag, "_first_fail_idx"}, first_fail_idx, 16'hFFFF);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        start_cyc = cyc;
    endtask

    task automatic wait_idle(input string name);
        int k = 0;
        while (res_q.size() != 0 && k < 800) begin
            @(negedge clk);
            k++;
        end
        if (res_q.size() != 0) begin
            chk({name, "_done_timeout"}, 64'd1, 64'd0);
            ops_q.delete();
            res_q.delete();
        end
    endtask

    task automatic run(input string name, input int dly, input bit never, input int fidx,
                       input bit poke, input bit check_first);
        int k = 0;
        resp_delay = dly;
        resp_never = never;
        fault_idx  = fidx;
        model_run();
        pulse_start();
        chk({name, "_busy_after_start"}, busy, 1);
        if (check_first) begin
            while (!op_valid && k < 30) begin
                @(negedge clk);
                k++;
            end
            chk({name, "_first_x1"}, x1, 8'h03);
            chk({name, "_first_x2"}, x2, 8'h02);
            chk({name, "_first_v"}, v, 8'h01);
            chk({name, "_first_t"}, t, 8'h03);
            chk({name, "_first_c"}, c, 8'h02);
            chk({name, "_first_a"}, dut_a, 16'd19);
            chk({name, "_first_b"}, dut_b, 16'd5);
        end
        if (poke) begin
            repeat (30) @(negedge clk);
            chk({name, "_busy_before_poke"}, busy, 1);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            repeat (40) @(negedge clk);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        wait_idle(name);
        repeat (20) @(negedge clk);
    endtask

    initial begin
        int k;
        bit saw_done;
        rst   = 1'b1;
        start = 1'b0;
        repeat (3) @(negedge clk);
        check_reset("reset");
        rst = 1'b0;

        run("ideal", 0, 1'b0, NO_FAULT, 1'b0, 1'b1);
        run("fault2", 0, 1'b0, 2, 1'b0, 1'b0);
        run("no_resp", 0, 1'b1, NO_FAULT, 1'b0, 1'b0);
        run("start_busy", 0, 1'b0, NO_FAULT, 1'b1, 1'b0);

        // Reset during WAIT of vector 5.
        resp_delay = 2;
        resp_never = 1'b0;
        fault_idx  = NO_FAULT;
        model_run();
        pulse_start();
        k = 0;
        while (vec_no < 6 && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk("reached_vec5_wait", op_valid, 1);
        rst = 1'b1;
        @(negedge clk);
        check_reset("midrun_reset");
        rst = 1'b0;
        ops_q.delete();
        res_q.delete();
        m_lfsr = 32'd1;
        saw_done = 1'b0;
        repeat (150) begin
            @(negedge clk);
            if (done) saw_done = 1'b1;
        end
        chk("no_done_after_reset", saw_done, 0);

        run("after_reset", 0, 1'b0, NO_FAULT, 1'b0, 1'b1);
        run("delay3", 3, 1'b0, NO_FAULT, 1'b0, 1'b0);
        run("delay4_timeout", 4, 1'b0, NO_FAULT, 1'b0, 1'b0);

        for (int r = 0; r < 4; r++) begin
            int d;
            int f;
            d = int'($urandom_range(0, 4));
            f = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, NV - 1)) : NO_FAULT;
            run("random", d, 1'b0, f, 1'b0, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
